seg_count_checker: RTL
======================

# seg_count_checker

Sequential monitor on the two-digit seven-segment bus driven by the team's up/down display counter. It decodes both digit patterns back to a binary value, tracks the count sequence, and flags illegal patterns, out-of-range values, wrong steps and stalls. It sits beside the counter on the same `clk`/`reset`/`mode` nets and is used in simulation and on-board as a self-check of the display path.

## Interface
- `N`, default 4: counter bit width. The legal range is 1..6, and the count modulus is 2^N.
- `HOLD_MAX`, default 0: maximum number of consecutive cycles the same value may be held before a stall is flagged. A value of 0 disables stall checking.
- `clk`  input  1: single clock. All logic is on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `mode`  input  1: direction of the observed counter. 1 means up and 0 means down.
- `seg_in`  input  [1:0][6:0]: segment patterns. `[1]` is the tens digit and `[0]` is the units digit. Bit 0 is segment a through bit 6 is segment g. Segments are active-low.
- `value`  output  7: last decoded value, equal to 10·tens + units.
- `value_valid`  output  1: `value` holds a legal decode from the previous cycle.
- `locked`  output  1: the checker is tracking the sequence.
- `seg_err`  output  1: one-cycle pulse for an illegal pattern or for a value ≥ 2^N.
- `step_err`  output  1: one-cycle pulse when the step is neither a hold nor the expected next value.
- `stall_err`  output  1: one-cycle pulse when a hold exceeds `HOLD_MAX`.
- `err_count`  output  8: saturating count of all error pulses. It is only live when the configuration macro is defined.

## Operation
- **Digit decode (active-low):**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other pattern is illegal.
- **Legal decode:** both digits decode and the value v < 2^N.
- **Expected next value** from the stored previous value p:
  - up: (p+1) mod 2^N
  - down: (p+2^N−1) mod 2^N
  - The check uses the `mode` sampled on the same edge as v.
- **FSM states:** `UNLOCKED` and `LOCKED`.
- **`UNLOCKED`:**
  - Legal decode: p ← v, go to `LOCKED`. No step check is made.
  - Illegal decode: `seg_err` pulses, state stays `UNLOCKED`.
- **`LOCKED`:**
  - Legal decode with v equal to the expected next value: p ← v, hold counter cleared.
  - Legal decode with v == p: hold counter increments. When it reaches `HOLD_MAX`, `stall_err` pulses once per stall episode. State stays `LOCKED`.
  - Legal decode with any other v: `step_err` pulses, p ← v (resync), state stays `LOCKED`.
  - Illegal decode: `seg_err` pulses, `value_valid` ← 0, go to `UNLOCKED`.
- **Wrap-around:**
  - up from 2^N−1 to 0 is legal.
  - down from 0 to 2^N−1 is legal.
- **Simultaneous events:** at most one error pulses per cycle. Priority is `seg_err` > `step_err` > `stall_err`.
- **Hold counter:** width is ⌈log2(HOLD_MAX+1)⌉. It saturates at `HOLD_MAX`.

## Timing
- **Reset values:**
  - `value` = 0
  - `value_valid` = 0
  - `locked` = 0
  - all error pulses = 0
  - `err_count` = 0
  - hold counter = 0
  - state = `UNLOCKED`
- **Reset mid-operation:** all state returns to reset values on the next rising edge. The `seg_in` present on the edge where reset is high is ignored.
- **Latency:** all outputs are registered with 1-cycle latency. The `seg_in` sampled at edge k is reflected in outputs after edge k.
- **Error pulses:** exactly one cycle wide. `err_count` updates on the same edge as the pulse.
- There is no handshake. `seg_in` is sampled every cycle.

## Configuration
- **Macro:** `SEG_CHECK_STATS_EN`.
- **Defined:** `err_count` increments on every `seg_err`, `step_err` or `stall_err` pulse and saturates at 255.
- **Undefined:** the counter logic is not built and `err_count` is tied to 0. All other behaviour is identical.

## Test plan
- **Up count and wrap:** N=4, `mode`=1, `seg_in` steps 13, 14, 15, 0, 1. Required response: `locked`=1 from the cycle after 13, `value` follows with 1-cycle delay, and no errors. For 15, `[1]`=1111001 and `[0]`=0010010.
- **Down count and wrap:** N=4, `mode`=0, sequence 1, 0, 15, 14. Required response: no errors and `value` = 1, 0, 15, 14.
- **Illegal and out-of-range patterns:** N=4.
  - `[0]`=1111111 while `LOCKED`: `seg_err` pulses, `locked` drops, `value_valid`=0.
  - Value 16: `seg_err` pulses.
  - Next legal value: relocks with no `step_err`.
- **Wrong step:** N=4, `mode`=1, sequence 3, 4, 7, 8. Required response: single `step_err` pulse on the cycle after 7 is sampled, then clean tracking from 7.
- **Stall:** `HOLD_MAX`=3, value 5 held for 6 cycles. Required response: one `stall_err` pulse after the 3rd repeat, no further pulses. Advancing to 6 clears the condition.
- **Reset mid-stream and stats:** with `SEG_CHECK_STATS_EN` defined, inject 3 errors so `err_count`=3, then assert `reset` for 1 cycle. Required response: every output returns to its reset value after that edge. Without the macro, `err_count` stays 0 throughout.

Source files
------------

// File: rtl/seg_count_checker.sv
// Self-check monitor for the two-digit seven-segment up/down counter display.
// Define SEG_CHECK_STATS_EN to build the saturating err_count; otherwise it is tied to 0.
module seg_count_checker #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [1:0][6:0] seg_in,
  output logic [6:0]      value,
  output logic            value_valid,
  output logic            locked,
  output logic            seg_err,
  output logic            step_err,
  output logic            stall_err,
  output logic [7:0]      err_count
);

  // state    | meaning
  // UNLOCKED | no trusted previous value; waiting for a legal decode
  // LOCKED   | tracking; each sample checked against hold / expected step
  typedef enum logic {UNLOCKED, LOCKED} state_t;

  localparam int         HW       = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [6:0] MOD_MAX  = 7'((1 << N) - 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [6:0]    value_d;
  logic          valid_d, seg_d, step_d, stall_d;

  logic [4:0] dec_t, dec_u;
  logic [6:0] v, exp_next;
  logic       legal;

  // Returns {ok, digit}; active-low pattern with bit 6 = segment g.
  function automatic logic [4:0] dec(input logic [6:0] s);
    case (s)
      7'b1000000: dec = 5'h10;
      7'b1111001: dec = 5'h11;
      7'b0100100: dec = 5'h12;
      7'b0110000: dec = 5'h13;
      7'b0011001: dec = 5'h14;
      7'b0010010: dec = 5'h15;
      7'b0000010: dec = 5'h16;
      7'b1111000: dec = 5'h17;
      7'b0000000: dec = 5'h18;
      7'b0010000: dec = 5'h19;
      default:    dec = 5'h00;
    endcase
  endfunction

  always_comb begin
    dec_t    = dec(seg_in[1]);
    dec_u    = dec(seg_in[0]);
    v        = {3'b000, dec_t[3:0]} * 7'd10 + {3'b000, dec_u[3:0]};
    legal    = dec_t[4] && dec_u[4] && (v <= MOD_MAX);
    // 7-bit wrap then mask is exact modulo 2^N since 128 is a multiple of 2^N
    exp_next = mode ? ((value + 7'd1) & MOD_MAX) : ((value - 7'd1) & MOD_MAX);
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    value_d = value;
    valid_d = value_valid;
    seg_d   = 1'b0;
    step_d  = 1'b0;
    stall_d = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (legal) begin
          value_d = v;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = LOCKED;
        end else begin
          seg_d   = 1'b1;
          valid_d = 1'b0;
        end
      end
      LOCKED: begin
        if (!legal) begin
          seg_d   = 1'b1;
          valid_d = 1'b0;
          hold_d  = '0;
          state_d = UNLOCKED;
        end else if (v == exp_next) begin
          value_d = v;
          hold_d  = '0;
        end else if (v == value) begin
          // saturating at the limit makes the stall pulse once per episode
          if (HOLD_MAX > 0 && hold_q != HOLD_LIM) begin
            hold_d  = hold_q + 1'b1;
            stall_d = (hold_d == HOLD_LIM);
          end
        end else begin
          step_d  = 1'b1;
          value_d = v;
          hold_d  = '0;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      hold_q      <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      seg_err     <= 1'b0;
      step_err    <= 1'b0;
      stall_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      value       <= value_d;
      value_valid <= valid_d;
      seg_err     <= seg_d;
      step_err    <= step_d;
      stall_err   <= stall_d;
    end
  end

  assign locked = (state_q == LOCKED);

`ifdef SEG_CHECK_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      err_count <= '0;
    else if ((seg_d || step_d || stall_d) && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'h00;
`endif

endmodule
